// File: rtl/frame_receiver.sv
// ---------------------------------------------------------------------------
// frame_receiver
//   Receive-side parser for the 13-byte controller frame
//     52 0D 01 D0 D1 D2 D3 D4 D5 D6 D7 CS 9A
//   with CS = ~(sum of all other frame bytes) mod 256.
//   Bytes arrive from the UART RX path as single-cycle rx_valid strobes.
//   Payload bytes are collected in a shadow buffer. They reach frame_data only
//   when the tail byte and the checksum are both correct. Every accepted frame
//   pulses frame_valid. Every rejected frame pulses frame_err and records its
//   cause in err_code. Each pulse bumps a wrap-around counter.
//
//   Optional feature: define FRAME_TIMEOUT_EN to abort a partial frame after
//   TIMEOUT_CYCLES idle cycles between bytes (err_code 5).
//
// Ports
//   clk           in   1      system clock, rising edge
//   rst           in   1      synchronous reset, active-high
//   rx_data       in   8      received byte
//   rx_valid      in   1      rx_data valid strobe
//   sel           in   3      payload byte index for preview_data
//   frame_data    out  64     last good payload, D0 in [63:56] .. D7 in [7:0]
//   preview_data  out  8      byte sel of frame_data (combinational)
//   frame_valid   out  1      one-cycle pulse, good frame accepted
//   frame_err     out  1      one-cycle pulse, frame rejected
//   err_code      out  3      1 len, 2 func, 3 checksum, 4 tail, 5 timeout
//   good_cnt      out  CNT_W  good frame count (wraps)
//   err_cnt       out  CNT_W  rejected frame count (wraps)
//   busy          out  1      parser is inside a frame
// ---------------------------------------------------------------------------
module frame_receiver #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic [2:0]       sel,
    output logic [63:0]      frame_data,
    output logic [7:0]       preview_data,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_FUNC = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CS   = 3'd4;
    localparam logic [2:0] S_TAIL = 3'd5;

    localparam logic [7:0] B_HDR  = 8'h52;
    localparam logic [7:0] B_LEN  = 8'h0D;
    localparam logic [7:0] B_FUNC = 8'h01;
    localparam logic [7:0] B_TAIL = 8'h9A;

    logic [2:0]       state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       cs_q, cs_d;
    logic [63:0]      shadow_q, shadow_d;
    logic [63:0]      frame_data_q, frame_data_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       chk_sum;
    logic [2:0]       sel_rev;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // sum_q already covers 52 0D 01 D0..D7; adding the tail and CS must give FF.
    assign chk_sum = sum_q + rx_data + cs_q;

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        idx_d         = idx_q;
        cs_d          = cs_q;
        shadow_d      = shadow_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        good_cnt_d    = good_cnt_q;
        err_cnt_d     = err_cnt_q;
`ifdef FRAME_TIMEOUT_EN
        tmo_d         = (rx_valid || state_q == S_HDR) ? '0 : tmo_q + 1'b1;
`endif

        if (rx_valid) begin
            case (state_q)
                S_HDR: begin
                    // Anything but a header byte is line noise and is dropped.
                    if (rx_data == B_HDR) begin
                        state_d = S_LEN;
                        sum_d   = B_HDR;
                    end
                end
                S_LEN: begin
                    if (rx_data == B_LEN) begin
                        state_d = S_FUNC;
                        sum_d   = sum_q + rx_data;
                    end else begin
                        state_d     = S_HDR;
                        frame_err_d = 1'b1;
                        err_code_d  = 3'd1;
                        err_cnt_d   = err_cnt_q + 1'b1;
                    end
                end
                S_FUNC: begin
                    if (rx_data == B_FUNC) begin
                        state_d = S_DATA;
                        sum_d   = sum_q + rx_data;
                        idx_d   = 3'd0;
                    end else begin
                        state_d     = S_HDR;
                        frame_err_d = 1'b1;
                        err_code_d  = 3'd2;
                        err_cnt_d   = err_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    // D0 lands in the top byte, so index 0 maps to bits [63:56].
                    shadow_d[{~idx_q, 3'b000} +: 8] = rx_data;
                    sum_d = sum_q + rx_data;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_CS;
                    end
                end
                S_CS: begin
                    cs_d    = rx_data;
                    state_d = S_TAIL;
                end
                S_TAIL: begin
                    state_d = S_HDR;
                    sum_d   = sum_q + rx_data;
                    if (rx_data != B_TAIL) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 3'd4;
                        err_cnt_d   = err_cnt_q + 1'b1;
                    end else if (chk_sum != 8'hFF) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 3'd3;
                        err_cnt_d   = err_cnt_q + 1'b1;
                    end else begin
                        frame_valid_d = 1'b1;
                        frame_data_d  = shadow_q;
                        good_cnt_d    = good_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end

`ifdef FRAME_TIMEOUT_EN
        // A byte in the expiry cycle takes precedence, hence the !rx_valid term.
        if (!rx_valid && state_q != S_HDR && tmo_q == TMO_LAST) begin
            state_d     = S_HDR;
            frame_err_d = 1'b1;
            err_code_d  = 3'd5;
            err_cnt_d   = err_cnt_q + 1'b1;
            tmo_d       = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_HDR;
            sum_q         <= '0;
            idx_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
            good_cnt_q    <= '0;
            err_cnt_q     <= '0;
`ifdef FRAME_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            idx_q         <= idx_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            good_cnt_q    <= good_cnt_d;
            err_cnt_q     <= err_cnt_d;
`ifdef FRAME_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    // Shadow payload and latched CS are only consumed after being rewritten
    // by the current frame, so they carry no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
        cs_q     <= cs_d;
    end

    assign sel_rev      = 3'd7 - sel;
    assign preview_data = frame_data_q[{sel_rev, 3'b000} +: 8];
    assign frame_data   = frame_data_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign err_code     = err_code_q;
    assign good_cnt     = good_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign busy         = (state_q != S_HDR);

endmodule

// File: tb/tb_frame_receiver.sv
module tb_frame_receiver;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [2:0]       sel;
    logic [63:0]      frame_data;
    logic [7:0]       preview_data;
    logic             frame_valid;
    logic             frame_err;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    frame_receiver #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .sel          (sel),
        .frame_data   (frame_data),
        .preview_data (preview_data),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             err;
        logic [2:0]       code;
        logic [63:0]      data;
        logic [CNT_W-1:0] good;
        logic [CNT_W-1:0] errc;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               passes = 0;
    logic [CNT_W-1:0] good_m = '0;
    logic [CNT_W-1:0] err_m  = '0;
    logic [2:0]       code_m = '0;
    logic [63:0]      data_m = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Record the outcome the next triggering byte/cycle must produce.
    task automatic push_exp(input logic err, input logic [2:0] code);
        exp_t e;
        if (err) begin
            err_m  = err_m + 1'b1;
            code_m = code;
        end else begin
            good_m = good_m + 1'b1;
        end
        e.err  = err;
        e.code = code_m;
        e.data = data_m;
        e.good = good_m;
        e.errc = err_m;
        q.push_back(e);
    endtask

    // Called #1 after each rising edge: a pending expectation must show up now.
    task automatic check_out();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("frame_valid", 64'(frame_valid), 64'(!e.err));
            chk("frame_err",   64'(frame_err),   64'(e.err));
            chk("err_code",    64'(err_code),    64'(e.code));
            chk("frame_data",  frame_data,       e.data);
            chk("good_cnt",    64'(good_cnt),    64'(e.good));
            chk("err_cnt",     64'(err_cnt),     64'(e.errc));
        end else begin
            chk("no_pulse", 64'({frame_valid, frame_err}), 64'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
            check_out();
        end
    endtask

    function automatic logic [7:0] cs_of(input logic [63:0] d);
        logic [7:0] s;
        s = 8'h52 + 8'h0D + 8'h01 + 8'h9A;
        for (int i = 0; i < 8; i++) s = s + d[8*i +: 8];
        return ~s;
    endfunction

    // Sends 01 D0..D7 CS tail, assuming 52 0D already went out.
    task automatic send_body(input logic [63:0] d, input logic [7:0] cs_xor,
                             input logic [7:0] tail);
        send_byte(8'h01);
        for (int i = 0; i < 8; i++) send_byte(d[63 - 8*i -: 8]);
        send_byte(cs_of(d) ^ cs_xor);
        if (tail != 8'h9A) push_exp(1'b1, 3'd4);
        else if (cs_xor != 8'h00) push_exp(1'b1, 3'd3);
        else begin
            data_m = d;
            push_exp(1'b0, 3'd0);
        end
        send_byte(tail);
    endtask

    task automatic send_frame(input logic [63:0] d, input logic [7:0] cs_xor,
                              input logic [7:0] tail);
        send_byte(8'h52);
        send_byte(8'h0D);
        send_body(d, cs_xor, tail);
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        sel      = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_frame_data", frame_data, 64'd0);
        chk("rst_flags", 64'({frame_valid, frame_err, busy}), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_cnts", 64'({good_cnt, err_cnt}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-zero payload: CS must be 05.
        chk("cs_zero_model", 64'(cs_of(64'd0)), 64'h05);
        send_frame(64'd0, 8'h00, 8'h9A);
        idle(1);

        // Payload 01..08, CS E1.
        send_frame(64'h0102030405060708, 8'h00, 8'h9A);
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            chk("preview_data", 64'(preview_data), 64'(data_m[63 - 8*i -: 8]));
        end
        sel = 3'd3;
        #1;
        chk("preview_sel3", 64'(preview_data), 64'h04);

        // Bad checksum, then bad tail with bad checksum (tail wins).
        send_frame(64'h0102030405060708, 8'h01, 8'h9A);
        send_frame(64'h0102030405060708, 8'h01, 8'h9B);
        chk("data_kept", frame_data, 64'h0102030405060708);

        // Noise, then a length error, then a frame carrying 0x52 as data.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h52);
        push_exp(1'b1, 3'd1);
        send_byte(8'h0E);
        chk("busy_after_err", 64'(busy), 64'd0);
        send_frame(64'h5211223344556652, 8'h00, 8'h9A);

        // Function-code error.
        send_byte(8'h52);
        send_byte(8'h0D);
        push_exp(1'b1, 3'd2);
        send_byte(8'h02);

        // Reset in the middle of a frame.
        send_byte(8'h52);
        send_byte(8'h0D);
        send_byte(8'h01);
        send_byte(8'hAA);
        chk("busy_mid_frame", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out();
        chk("mid_rst_data", frame_data, 64'd0);
        chk("mid_rst_flags", 64'({frame_valid, frame_err, busy}), 64'd0);
        chk("mid_rst_code_cnts", 64'({err_code, good_cnt, err_cnt}), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        good_m = '0;
        err_m  = '0;
        code_m = '0;
        data_m = '0;
        send_frame(64'hA1B2C3D4E5F60718, 8'h00, 8'h9A);

`ifdef FRAME_TIMEOUT_EN
        send_byte(8'h52);
        send_byte(8'h0D);
        idle(9);
        chk("busy_before_tmo", 64'(busy), 64'd1);
        push_exp(1'b1, 3'd5);
        idle(1);
        chk("busy_after_tmo", 64'(busy), 64'd0);
        send_byte(8'h52);
        send_byte(8'h0D);
        idle(9);
        send_body(64'h0011223344556677, 8'h00, 8'h9A);
`else
        // Without the timeout a stalled frame simply waits.
        send_byte(8'h52);
        send_byte(8'h0D);
        idle(20);
        chk("busy_stalled", 64'(busy), 64'd1);
        send_body(64'h0011223344556677, 8'h00, 8'h9A);
`endif
        idle(2);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
